tag_lookup_ctrl: RTL and testbench
==================================

# tag_lookup_ctrl

Tag-lookup controller for one processor's MSI cache, sitting directly upstream of the synchronous-read tag RAM (8 sets, 11-bit entries = 9-bit tag + 2-bit MSI state). It arbitrates processor requests, bus snoops and state updates from the bus controller onto the single RAM port. It compares the returned tag, reports hit/miss/state, and applies snoop-induced MSI downgrades.

## Interface
- AWIDTH, 3, set-index width (8 sets)
- TWIDTH, 9, tag width; RAM entry width DWIDTH = TWIDTH+2, entry = {tag, state}
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1  processor request handshake
- req_addr  in  TWIDTH+AWIDTH  {tag, index}
- req_write  in  1  1 = store, 0 = load
- resp_valid  out  1  one-cycle processor response strobe
- resp_hit, resp_need_bus  out  1  hit flag; bus transaction required
- resp_state  out  2  line state read
- resp_victim_tag  out  TWIDTH  stored tag (for writeback)
- resp_victim_dirty  out  1  stored line valid-M on a miss
- snp_valid / snp_ready  in / out  1  snoop handshake
- snp_addr  in  TWIDTH+AWIDTH  snooped address
- snp_rdx  in  1  1 = BusRdX, 0 = BusRd
- snp_resp_valid, snp_hit, snp_flush  out  1  snoop result; flush = line was M
- upd_valid / upd_ready  in / out  1  state-update handshake from bus controller
- upd_index  in  AWIDTH; upd_tag  in  TWIDTH; upd_state  in  2
- ram_addr  out  AWIDTH; ram_din  out  DWIDTH; ram_we  out  1; ram_dout  in  DWIDTH

## Operation
- MSI encoding: I=00, S=01, M=10; 11 treated as I.
- FSM: IDLE, LOOKUP, RESP.
- IDLE priority is upd > snp > req.
  - upd_ready = IDLE.
  - snp_ready = IDLE & !upd_valid.
  - req_ready = IDLE & !upd_valid & !snp_valid.
- Update accept: ram_we=1, ram_addr=upd_index, ram_din={upd_tag,upd_state} combinationally in the same cycle; stay IDLE.
- Snoop/req accept: ram_addr = index of accepted address (combinational); capture tag, index, op, source; go LOOKUP.
- LOOKUP: ram_dout is valid. hit = (stored tag == captured tag) & state ∈ {S,M}.
  - Processor request:
    - resp_need_bus = !hit | (req_write & state==S).
    - resp_victim_dirty = !hit & state==M.
    - Register results; go RESP.
  - Snoop:
    - On hit with BusRd in M: write state S.
    - On hit with BusRdX: write state I.
    - The write is made via ram_we in this cycle, with the tag unchanged.
    - snp_flush = hit & state==M.
    - Register results; go RESP.
- RESP: resp_valid or snp_resp_valid high for one cycle, with result fields held stable; return to IDLE.
- Block never changes state for processor requests; the bus controller issues upd after completing the transaction.

## Timing
- Accept at edge E0. RAM latches the address at E0, compare happens in the cycle after E0, and the response strobe is high in the cycle after E1. Latency is 2 cycles; throughput is one lookup per 3 cycles.
- Update is zero-latency: written at the accept edge. A snoop accepted at the next edge reads the new value.
- Snoop downgrade is written at E1. Any lookup accepted after RESP sees the downgraded state.
- Simultaneous upd+snp+req: upd is served first, then snp, then req. req_valid must be held until accepted.
- Reset (async assert): FSM=IDLE, all outputs 0 (ram_addr=0, ram_we=0, resp_*/snp_*=0).
  - Reset mid-LOOKUP drops the transaction: no RAM write, no response.
  - RAM contents are not reset.
- ram_we is never asserted in RESP or under reset.

## Structure
- Package msi_pkg holds:
  - state encodings I/S/M
  - FSM state enum
  - the AWIDTH/TWIDTH defaults
  - address tag/index slicing functions
- One sub-module, msi_snoop_next: combinational {state, rdx} -> {next_state, flush, write_needed}.
- The tag RAM is instantiated outside this block, at processor level.

## Test plan
- Preload set 2 = {tag 0x055, S}. Load addr {0x055,2} -> resp_hit=1, resp_state=S, resp_need_bus=0, two cycles after accept.
- Same set, store -> resp_hit=1, resp_need_bus=1 (upgrade). Then upd {2,0x055,M} -> RAM entry 2 = {0x055,M}.
- Set 5 = {0x1A0, M}. Load {0x0FF,5} -> resp_hit=0, resp_need_bus=1, resp_victim_dirty=1, resp_victim_tag=0x1A0.
- Set 5 = {0x1A0, M}, BusRd snoop {0x1A0,5} -> snp_hit=1, snp_flush=1, entry becomes S.
  - A following BusRdX snoop -> snp_flush=0, entry becomes I.
- Assert upd, snp and req in the same cycle -> upd written first, snp_ready, then req_ready. Each response is produced in order.
- Assert reset_n low during LOOKUP -> no ram_we, no resp_valid. After release, req_ready=1 next cycle.

Source files
------------

// File: rtl/msi_pkg.sv
// msi_pkg: shared definitions for the tag-lookup controller.
//   - MSI line-state encodings (I=00, S=01, M=10; 11 is treated as I)
//   - FSM state enum for tag_lookup_ctrl
//   - default set-index / tag widths
//   - helpers to split a {tag, index} address and to normalise a state
package msi_pkg;

    localparam int AWIDTH_DEF = 3;
    localparam int TWIDTH_DEF = 9;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_LOOKUP = 2'd1,
        FSM_RESP   = 2'd2
    } fsm_state_e;

    function automatic logic [TWIDTH_DEF-1:0] addr_tag(
        input logic [TWIDTH_DEF+AWIDTH_DEF-1:0] addr
    );
        return addr[TWIDTH_DEF+AWIDTH_DEF-1:AWIDTH_DEF];
    endfunction

    function automatic logic [AWIDTH_DEF-1:0] addr_index(
        input logic [TWIDTH_DEF+AWIDTH_DEF-1:0] addr
    );
        return addr[AWIDTH_DEF-1:0];
    endfunction

    // The unused encoding 11 behaves exactly like Invalid.
    function automatic logic [1:0] norm_state(input logic [1:0] st);
        return (st == 2'b11) ? ST_I : st;
    endfunction

endpackage

// File: rtl/msi_snoop_next.sv
// msi_snoop_next: MSI reaction of a line that a snoop has hit.
//   state_i        : current (normalised) line state
//   rdx_i          : 1 = BusRdX, 0 = BusRd
//   next_state_o   : state the line must move to
//   flush_o        : line was Modified, data must be supplied
//   write_needed_o : the tag RAM entry has to be rewritten
module msi_snoop_next
    import msi_pkg::*;
(
    input  logic [1:0] state_i,
    input  logic       rdx_i,
    output logic [1:0] next_state_o,
    output logic       flush_o,
    output logic       write_needed_o
);

    always_comb begin
        next_state_o   = state_i;
        flush_o        = 1'b0;
        write_needed_o = 1'b0;
        case (state_i)
            ST_M: begin
                flush_o        = 1'b1;
                write_needed_o = 1'b1;
                next_state_o   = rdx_i ? ST_I : ST_S;
            end
            ST_S: begin
                if (rdx_i) begin
                    next_state_o   = ST_I;
                    write_needed_o = 1'b1;
                end
            end
            default: next_state_o = ST_I;
        endcase
    end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl: arbitrates processor requests, bus snoops and state
// updates onto a single synchronous-read tag RAM port (entry = {tag, state}).
//   clock, reset_n                      : clock, async active-low reset
//   req_*                               : processor lookup request / response
//   snp_*                               : bus snoop request / response
//   upd_*                               : state write from the bus controller
//   ram_addr, ram_din, ram_we, ram_dout : tag RAM port (1-cycle read latency)
//   dbg_state                           : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid and its payload must stay stable until that edge, and
// ready never depends on the same channel's valid.
module tag_lookup_ctrl
    import msi_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int TWIDTH = TWIDTH_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [TWIDTH+AWIDTH-1:0] req_addr,
    input  logic                     req_write,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic                     resp_need_bus,
    output logic [1:0]               resp_state,
    output logic [TWIDTH-1:0]        resp_victim_tag,
    output logic                     resp_victim_dirty,
    input  logic                     snp_valid,
    output logic                     snp_ready,
    input  logic [TWIDTH+AWIDTH-1:0] snp_addr,
    input  logic                     snp_rdx,
    output logic                     snp_resp_valid,
    output logic                     snp_hit,
    output logic                     snp_flush,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [AWIDTH-1:0]        upd_index,
    input  logic [TWIDTH-1:0]        upd_tag,
    input  logic [1:0]               upd_state,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic [TWIDTH+1:0]        ram_din,
    output logic                     ram_we,
    input  logic [TWIDTH+1:0]        ram_dout,
    output fsm_state_e               dbg_state
);

    fsm_state_e        state_q, state_d;
    logic [TWIDTH-1:0] tag_q, tag_d;
    logic [AWIDTH-1:0] idx_q, idx_d;
    logic              write_q, write_d;
    logic              is_snp_q, is_snp_d;
    logic              rdx_q, rdx_d;

    logic              resp_hit_q, resp_hit_d;
    logic              resp_need_bus_q, resp_need_bus_d;
    logic [1:0]        resp_state_q, resp_state_d;
    logic [TWIDTH-1:0] resp_victim_tag_q, resp_victim_tag_d;
    logic              resp_victim_dirty_q, resp_victim_dirty_d;
    logic              snp_hit_q, snp_hit_d;
    logic              snp_flush_q, snp_flush_d;

    logic [TWIDTH-1:0] stored_tag;
    logic [1:0]        stored_state;
    logic              hit;
    logic [1:0]        snp_next_state;
    logic              snp_flush_c;
    logic              snp_write_needed;

    logic [AWIDTH-1:0] ram_addr_c;
    logic [TWIDTH+1:0] ram_din_c;
    logic              ram_we_c;
    logic              upd_ready_c, snp_ready_c, req_ready_c;

    assign stored_tag   = ram_dout[TWIDTH+1:2];
    assign stored_state = norm_state(ram_dout[1:0]);
    assign hit          = (stored_tag == tag_q) &&
                          ((stored_state == ST_S) || (stored_state == ST_M));

    msi_snoop_next u_snoop_next (
        .state_i        (stored_state),
        .rdx_i          (rdx_q),
        .next_state_o   (snp_next_state),
        .flush_o        (snp_flush_c),
        .write_needed_o (snp_write_needed)
    );

    always_comb begin
        state_d             = state_q;
        tag_d               = tag_q;
        idx_d               = idx_q;
        write_d             = write_q;
        is_snp_d            = is_snp_q;
        rdx_d               = rdx_q;
        resp_hit_d          = resp_hit_q;
        resp_need_bus_d     = resp_need_bus_q;
        resp_state_d        = resp_state_q;
        resp_victim_tag_d   = resp_victim_tag_q;
        resp_victim_dirty_d = resp_victim_dirty_q;
        snp_hit_d           = snp_hit_q;
        snp_flush_d         = snp_flush_q;
        ram_addr_c          = idx_q;
        ram_din_c           = '0;
        ram_we_c            = 1'b0;
        upd_ready_c         = 1'b0;
        snp_ready_c         = 1'b0;
        req_ready_c         = 1'b0;

        case (state_q)
            FSM_IDLE: begin
                upd_ready_c = 1'b1;
                snp_ready_c = !upd_valid;
                req_ready_c = !upd_valid && !snp_valid;
                if (upd_valid) begin
                    // Zero-latency write; FSM stays idle.
                    ram_we_c   = 1'b1;
                    ram_addr_c = upd_index;
                    ram_din_c  = {upd_tag, upd_state};
                end else if (snp_valid) begin
                    ram_addr_c = addr_index(snp_addr);
                    idx_d      = addr_index(snp_addr);
                    tag_d      = addr_tag(snp_addr);
                    rdx_d      = snp_rdx;
                    write_d    = 1'b0;
                    is_snp_d   = 1'b1;
                    state_d    = FSM_LOOKUP;
                end else if (req_valid) begin
                    ram_addr_c = addr_index(req_addr);
                    idx_d      = addr_index(req_addr);
                    tag_d      = addr_tag(req_addr);
                    rdx_d      = 1'b0;
                    write_d    = req_write;
                    is_snp_d   = 1'b0;
                    state_d    = FSM_LOOKUP;
                end
            end
            FSM_LOOKUP: begin
                state_d = FSM_RESP;
                if (is_snp_q) begin
                    snp_hit_d   = hit;
                    snp_flush_d = hit && snp_flush_c;
                    // Downgrade keeps the tag; only the state field changes.
                    if (hit && snp_write_needed) begin
                        ram_we_c  = 1'b1;
                        ram_din_c = {stored_tag, snp_next_state};
                    end
                end else begin
                    resp_hit_d          = hit;
                    resp_state_d        = stored_state;
                    resp_victim_tag_d   = stored_tag;
                    resp_need_bus_d     = !hit || (write_q && (stored_state == ST_S));
                    resp_victim_dirty_d = !hit && (stored_state == ST_M);
                end
            end
            FSM_RESP: begin
                state_d = FSM_IDLE;
            end
            default: state_d = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= FSM_IDLE;
            tag_q               <= '0;
            idx_q               <= '0;
            write_q             <= 1'b0;
            is_snp_q            <= 1'b0;
            rdx_q               <= 1'b0;
            resp_hit_q          <= 1'b0;
            resp_need_bus_q     <= 1'b0;
            resp_state_q        <= '0;
            resp_victim_tag_q   <= '0;
            resp_victim_dirty_q <= 1'b0;
            snp_hit_q           <= 1'b0;
            snp_flush_q         <= 1'b0;
        end else begin
            state_q             <= state_d;
            tag_q               <= tag_d;
            idx_q               <= idx_d;
            write_q             <= write_d;
            is_snp_q            <= is_snp_d;
            rdx_q               <= rdx_d;
            resp_hit_q          <= resp_hit_d;
            resp_need_bus_q     <= resp_need_bus_d;
            resp_state_q        <= resp_state_d;
            resp_victim_tag_q   <= resp_victim_tag_d;
            resp_victim_dirty_q <= resp_victim_dirty_d;
            snp_hit_q           <= snp_hit_d;
            snp_flush_q         <= snp_flush_d;
        end
    end

    // Combinational outputs are forced low while reset is held, so an update
    // presented during reset can never reach the RAM.
    assign ram_we    = ram_we_c && reset_n;
    assign ram_addr  = reset_n ? ram_addr_c : '0;
    assign ram_din   = reset_n ? ram_din_c : '0;
    assign upd_ready = upd_ready_c && reset_n;
    assign snp_ready = snp_ready_c && reset_n;
    assign req_ready = req_ready_c && reset_n;

    assign resp_valid        = (state_q == FSM_RESP) && !is_snp_q;
    assign snp_resp_valid    = (state_q == FSM_RESP) && is_snp_q;
    assign resp_hit          = resp_hit_q;
    assign resp_need_bus     = resp_need_bus_q;
    assign resp_state        = resp_state_q;
    assign resp_victim_tag   = resp_victim_tag_q;
    assign resp_victim_dirty = resp_victim_dirty_q;
    assign snp_hit           = snp_hit_q;
    assign snp_flush         = snp_flush_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
module tb_tag_lookup_ctrl;
    import msi_pkg::*;

    localparam int AW     = 3;
    localparam int TW     = 9;
    localparam int BUDGET = 20;

    logic          clock;
    logic          reset_n;
    logic          req_valid, req_ready, req_write;
    logic [TW+AW-1:0] req_addr;
    logic          resp_valid, resp_hit, resp_need_bus, resp_victim_dirty;
    logic [1:0]    resp_state;
    logic [TW-1:0] resp_victim_tag;
    logic          snp_valid, snp_ready, snp_rdx;
    logic [TW+AW-1:0] snp_addr;
    logic          snp_resp_valid, snp_hit, snp_flush;
    logic          upd_valid, upd_ready;
    logic [AW-1:0] upd_index;
    logic [TW-1:0] upd_tag;
    logic [1:0]    upd_state;
    logic [AW-1:0] ram_addr;
    logic [TW+1:0] ram_din, ram_dout;
    logic          ram_we;
    fsm_state_e    dbg_state;

    // Tag RAM model: synchronous read, not reset.
    logic [TW+1:0] mem [0:7];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Response vector: {is_snp, hit, state[1:0], need_bus, victim_tag[8:0], dirty, flush}
    logic [15:0] exp_q[$];
    int          acc_q[$];

    tag_lookup_ctrl #(.AWIDTH(AW), .TWIDTH(TW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_need_bus(resp_need_bus),
        .resp_state(resp_state), .resp_victim_tag(resp_victim_tag),
        .resp_victim_dirty(resp_victim_dirty),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_addr(snp_addr), .snp_rdx(snp_rdx),
        .snp_resp_valid(snp_resp_valid), .snp_hit(snp_hit), .snp_flush(snp_flush),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
        .upd_tag(upd_tag), .upd_state(upd_state),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_req(input logic hit, input logic [1:0] st,
                                           input logic need, input logic [8:0] vtag,
                                           input logic dirty);
        return {1'b0, hit, st, need, vtag, dirty, 1'b0};
    endfunction

    function automatic logic [15:0] mk_snp(input logic hit, input logic flush);
        return {1'b1, hit, 2'b00, 1'b0, 9'h000, 1'b0, flush};
    endfunction

    function automatic logic [11:0] mk_addr(input logic [8:0] tag, input logic [2:0] idx);
        return {tag, idx};
    endfunction

    // ---------------- drivers ----------------
    task automatic do_req(input logic [11:0] addr, input logic wr, input logic [15:0] exp,
                          input bit push, output int acc);
        int n;
        @(negedge clock);
        req_addr = addr; req_write = wr; req_valid = 1'b1;
        #1; n = 0;
        while (!req_ready && n < BUDGET) begin @(negedge clock); #1; n++; end
        acc = cyc;
        if (!req_ready) begin
            checks++; fails++;
            $display("FAIL req_handshake: req_ready stayed 0, required 1 within %0d cycles", BUDGET);
        end else begin
            @(posedge clock); #1;
            if (push) begin exp_q.push_back(exp); acc_q.push_back(acc); end
        end
        req_valid = 1'b0;
    endtask

    task automatic do_snp(input logic [11:0] addr, input logic rdx, input logic [15:0] exp,
                          input bit push, output int acc);
        int n;
        @(negedge clock);
        snp_addr = addr; snp_rdx = rdx; snp_valid = 1'b1;
        #1; n = 0;
        while (!snp_ready && n < BUDGET) begin @(negedge clock); #1; n++; end
        acc = cyc;
        if (!snp_ready) begin
            checks++; fails++;
            $display("FAIL snp_handshake: snp_ready stayed 0, required 1 within %0d cycles", BUDGET);
        end else begin
            @(posedge clock); #1;
            if (push) begin exp_q.push_back(exp); acc_q.push_back(acc); end
        end
        snp_valid = 1'b0;
    endtask

    task automatic do_upd(input logic [2:0] idx, input logic [8:0] tag, input logic [1:0] st,
                          output int acc);
        int n;
        @(negedge clock);
        upd_index = idx; upd_tag = tag; upd_state = st; upd_valid = 1'b1;
        #1; n = 0;
        while (!upd_ready && n < BUDGET) begin @(negedge clock); #1; n++; end
        acc = cyc;
        if (!upd_ready) begin
            checks++; fails++;
            $display("FAIL upd_handshake: upd_ready stayed 0, required 1 within %0d cycles", BUDGET);
        end else begin
            @(posedge clock); #1;
        end
        upd_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [15:0] act, exp;
        int          acc;
        if (!reset_n) check("ram_we_in_reset", ram_we, 1'b0);
        if (dbg_state == FSM_RESP) check("ram_we_in_resp", ram_we, 1'b0);
        if (resp_valid && snp_resp_valid) begin
            checks++; fails++;
            $display("FAIL both_strobes: resp_valid=1 snp_resp_valid=1, required at most one");
        end else if (resp_valid || snp_resp_valid) begin
            if (resp_valid)
                act = {1'b0, resp_hit, resp_state, resp_need_bus, resp_victim_tag,
                       resp_victim_dirty, 1'b0};
            else
                act = {1'b1, snp_hit, 2'b00, 1'b0, 9'h000, 1'b0, snp_flush};
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_response: got %0h, required no response", act);
            end else begin
                exp = exp_q.pop_front();
                acc = acc_q.pop_front();
                check("response_fields", act, exp);
                check("response_latency", cyc - acc, 2);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0, a1, a2;
        reset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        snp_valid = 1'b0; snp_rdx = 1'b0; snp_addr = '0;
        upd_valid = 1'b0; upd_index = '0; upd_tag = '0; upd_state = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[2] = {9'h055, ST_S};
        mem[5] = {9'h1A0, ST_M};

        repeat (3) @(negedge clock);
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_snp_resp_valid", snp_resp_valid, 1'b0);
        check("reset_ram_we", ram_we, 1'b0);
        check("reset_ram_addr", ram_addr, 3'd0);
        check("reset_state", dbg_state, FSM_IDLE);
        #1 reset_n = 1'b1;
        #1 check("req_ready_after_reset", req_ready, 1'b1);

        // Load hit on S, then store upgrade, then bus controller upgrades to M.
        do_req(mk_addr(9'h055, 3'd2), 1'b0, mk_req(1'b1, ST_S, 1'b0, 9'h055, 1'b0), 1, a0);
        do_req(mk_addr(9'h055, 3'd2), 1'b1, mk_req(1'b1, ST_S, 1'b1, 9'h055, 1'b0), 1, a0);
        do_upd(3'd2, 9'h055, ST_M, a0);
        @(negedge clock);
        check("upd_set2_to_M", mem[2], {9'h055, ST_M});

        // Miss against a dirty line.
        do_req(mk_addr(9'h0FF, 3'd5), 1'b0, mk_req(1'b0, ST_M, 1'b1, 9'h1A0, 1'b1), 1, a0);

        // BusRd on M flushes and downgrades to S, BusRdX then invalidates.
        do_snp(mk_addr(9'h1A0, 3'd5), 1'b0, mk_snp(1'b1, 1'b1), 1, a0);
        repeat (3) @(negedge clock);
        check("busrd_set5_to_S", mem[5], {9'h1A0, ST_S});
        do_snp(mk_addr(9'h1A0, 3'd5), 1'b1, mk_snp(1'b1, 1'b0), 1, a0);
        repeat (3) @(negedge clock);
        check("busrdx_set5_to_I", mem[5], {9'h1A0, ST_I});
        do_req(mk_addr(9'h1A0, 3'd5), 1'b0, mk_req(1'b0, ST_I, 1'b1, 9'h1A0, 1'b0), 1, a0);

        // Simultaneous upd + snp + req: served in that order.
        fork
            do_upd(3'd3, 9'h0AA, ST_S, a0);
            do_snp(mk_addr(9'h0AA, 3'd3), 1'b0, mk_snp(1'b1, 1'b0), 1, a1);
            do_req(mk_addr(9'h0AA, 3'd3), 1'b0, mk_req(1'b1, ST_S, 1'b0, 9'h0AA, 1'b0), 1, a2);
        join
        check("order_snp_after_upd", a1 - a0, 1);
        check("order_req_after_snp", a2 - a1, 3);
        repeat (3) @(negedge clock);
        check("set3_after_busrd_on_S", mem[3], {9'h0AA, ST_S});

        // Snoop miss leaves the entry alone.
        do_snp(mk_addr(9'h011, 3'd3), 1'b1, mk_snp(1'b0, 1'b0), 1, a0);
        repeat (3) @(negedge clock);
        check("snoop_miss_no_write", mem[3], {9'h0AA, ST_S});

        // Reset in the middle of a downgrading snoop lookup drops it.
        do_snp(mk_addr(9'h0AA, 3'd3), 1'b1, 16'h0000, 0, a0);
        @(negedge clock);
        check("mid_lookup_state", dbg_state, FSM_LOOKUP);
        check("mid_lookup_we_before_reset", ram_we, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_lookup_we_in_reset", ram_we, 1'b0);
        check("mid_lookup_state_in_reset", dbg_state, FSM_IDLE);
        check("mid_lookup_snp_resp", snp_resp_valid, 1'b0);
        check("req_ready_in_reset", req_ready, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1 check("req_ready_after_release", req_ready, 1'b1);
        check("set3_unchanged_after_reset", mem[3], {9'h0AA, ST_S});

        do_req(mk_addr(9'h0AA, 3'd3), 1'b1, mk_req(1'b1, ST_S, 1'b1, 9'h0AA, 1'b0), 1, a0);

        repeat (5) @(negedge clock);
        check("all_responses_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
